// File: rtl/neur_accum_quant_if.sv
// rtl/neur_accum_quant_if.sv - control/data bundle between a host and neur_accum_quant
interface neur_accum_quant_if #(
    parameter int N_CH  = 4,
    parameter int PS_W  = 32,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
);
    logic                  bias_valid_i;
    logic [N_CH*8-1:0]     bias_i;
    logic [N_CH*5-1:0]     bias_shift_i;
    logic                  psum_valid_i;
    logic [N_CH*PS_W-1:0]  psum_i;
    logic [N_CH*16-1:0]    mul_i;
    logic [N_CH*5-1:0]     shift_i;
    logic                  relu_en_i;
    logic                  get_res_i;
    logic                  busy_o;
    logic                  res_valid_o;
    logic [N_CH*OUT_W-1:0] res_o;
    logic [N_CH*ACC_W-1:0] acc_o;
    logic                  overflow_o;

    modport master (
        output bias_valid_i, bias_i, bias_shift_i, psum_valid_i, psum_i,
               mul_i, shift_i, relu_en_i, get_res_i,
        input  busy_o, res_valid_o, res_o, acc_o, overflow_o
    );

    modport slave (
        input  bias_valid_i, bias_i, bias_shift_i, psum_valid_i, psum_i,
               mul_i, shift_i, relu_en_i, get_res_i,
        output busy_o, res_valid_o, res_o, acc_o, overflow_o
    );
endinterface

// File: rtl/neur_accum_quant.sv
// rtl/neur_accum_quant.sv - per-channel saturating accumulator with serial requantization
module neur_accum_quant #(
    parameter int N_CH  = 4,
    parameter int PS_W  = 32,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    neur_accum_quant_if.slave bus
);
    localparam int PW = ACC_W + 16;
    localparam int QW = PW + 1;
    localparam int CW = $clog2(N_CH + 1);

    localparam logic signed [QW-1:0]    OMAX = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [QW-1:0]    OMIN = ~OMAX;
    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AMIN = ~AMAX;

    typedef enum logic [1:0] {IDLE, ACC, QUANT, DONE} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc [N_CH];
    logic [N_CH*OUT_W-1:0]   res;
    logic                    overflow;
    logic                    busy;
    logic                    res_valid;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           p_idx;
    logic                    p_vld;
    logic signed [PW-1:0]    p_reg;
    logic [4:0]              p_sh;
    logic [N_CH*16-1:0]      mul_q;
    logic [N_CH*5-1:0]       shift_q;
    logic                    relu_q;

    // Accumulate and bias-load candidates for every channel in parallel
    logic signed [ACC_W:0]   sum_w  [N_CH];
    logic signed [ACC_W-1:0] sat_w  [N_CH];
    logic signed [ACC_W-1:0] bias_w [N_CH];
    logic [N_CH-1:0]         sat_hit;

    always_comb begin
        sat_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            sum_w[c] = {acc[c][ACC_W-1], acc[c]}
                     + {{(ACC_W-PS_W+1){bus.psum_i[c*PS_W+PS_W-1]}}, bus.psum_i[c*PS_W +: PS_W]};
            sat_w[c] = sum_w[c][ACC_W-1:0];
            if (sum_w[c][ACC_W] != sum_w[c][ACC_W-1]) begin
                sat_hit[c] = 1'b1;
                sat_w[c]   = sum_w[c][ACC_W] ? AMIN : AMAX;
            end
            bias_w[c] = {{(ACC_W-8){bus.bias_i[c*8+7]}}, bus.bias_i[c*8 +: 8]}
                      << bus.bias_shift_i[c*5 +: 5];
        end
    end

    // Requant stage 1: multiply the channel selected by cnt
    logic signed [ACC_W-1:0] sel_acc;
    logic signed [15:0]      sel_mul;
    logic [4:0]              sel_sh;
    logic signed [PW-1:0]    prod;

    always_comb begin
        sel_acc = '0;
        sel_mul = '0;
        sel_sh  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cnt == CW'(c)) begin
                sel_acc = acc[c];
                sel_mul = mul_q[c*16 +: 16];
                sel_sh  = shift_q[c*5 +: 5];
            end
        end
        prod = $signed({{16{sel_acc[ACC_W-1]}}, sel_acc}) * $signed({{ACC_W{sel_mul[15]}}, sel_mul});
    end

    // Requant stage 2: round, shift, optional relu, saturate to OUT_W
    logic signed [QW-1:0] rnd;
    logic signed [QW-1:0] rounded;
    logic signed [QW-1:0] shifted;
    logic [OUT_W-1:0]     qv;

    always_comb begin
        rnd     = (p_sh == 5'd0) ? '0 : (QW'(1) << (p_sh - 5'd1));
        rounded = {p_reg[PW-1], p_reg} + rnd;
        shifted = rounded >>> p_sh;
        if (relu_q && shifted[QW-1]) begin
            shifted = '0;
        end
        if (shifted > OMAX) begin
            qv = OMAX[OUT_W-1:0];
        end else if (shifted < OMIN) begin
            qv = OMIN[OUT_W-1:0];
        end else begin
            qv = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            for (int c = 0; c < N_CH; c++) acc[c] <= '0;
            res       <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            cnt       <= '0;
            p_idx     <= '0;
            p_vld     <= 1'b0;
            p_reg     <= '0;
            p_sh      <= '0;
            mul_q     <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, ACC, DONE: begin
                    if (bus.bias_valid_i) begin
                        for (int c = 0; c < N_CH; c++) acc[c] <= bias_w[c];
                        overflow <= 1'b0;
                        state    <= ACC;
                    end else if (bus.get_res_i) begin
                        mul_q   <= bus.mul_i;
                        shift_q <= bus.shift_i;
                        relu_q  <= bus.relu_en_i;
                        cnt     <= '0;
                        p_vld   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= QUANT;
                    end else if (state == ACC && bus.psum_valid_i) begin
                        for (int c = 0; c < N_CH; c++) acc[c] <= sat_w[c];
                        if (|sat_hit) overflow <= 1'b1;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                QUANT: begin
                    if (cnt != CW'(N_CH)) begin
                        p_reg <= prod;
                        p_sh  <= sel_sh;
                        p_idx <= cnt;
                        cnt   <= cnt + 1'b1;
                    end
                    p_vld <= (cnt != CW'(N_CH));
                    if (p_vld) begin
                        for (int c = 0; c < N_CH; c++) begin
                            if (p_idx == CW'(c)) res[c*OUT_W +: OUT_W] <= qv;
                        end
                        if (p_idx == CW'(N_CH-1)) begin
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = busy;
    assign bus.res_valid_o = res_valid;
    assign bus.res_o       = res;
    assign bus.overflow_o  = overflow;

    for (genvar g = 0; g < N_CH; g++) begin : g_acc_out
        assign bus.acc_o[g*ACC_W +: ACC_W] = acc[g];
    end
endmodule

// File: tb/tb_neur_accum_quant.sv
// tb/tb_neur_accum_quant.sv - self-checking bench for neur_accum_quant
module tb_neur_accum_quant;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neur_accum_quant_if #(.N_CH(N), .PS_W(32), .ACC_W(32), .OUT_W(8)) bus ();

    neur_accum_quant #(.N_CH(N), .PS_W(32), .ACC_W(32), .OUT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_acc [N];
    int m_res [N];
    bit m_ovf;
    bit m_in_acc;

    int t_bias [N];
    int t_bsh  [N];
    int t_psum [N];
    int t_mul  [N];
    int t_sh   [N];
    bit t_relu;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qmodel(input int a, input int m, input int s, input bit relu);
        longint p;
        p = longint'(a) * longint'(m);
        if (s > 0) p = p + (longint'(1) << (s - 1));
        p = p >>> s;
        if (relu && p < 0) p = 0;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return int'(p);
    endfunction

    task automatic check_state(input string tag);
        for (int c = 0; c < N; c++)
            chk($sformatf("%s acc%0d", tag, c), $signed(bus.acc_o[c*32 +: 32]), m_acc[c]);
        chk($sformatf("%s overflow", tag), {63'd0, bus.overflow_o}, {63'd0, m_ovf});
    endtask

    task automatic check_res(input string tag);
        for (int c = 0; c < N; c++)
            chk($sformatf("%s res%0d", tag, c), $signed(bus.res_o[c*8 +: 8]), m_res[c]);
    endtask

    task automatic do_bias(input bit with_psum);
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            bus.bias_i[c*8 +: 8]       = t_bias[c][7:0];
            bus.bias_shift_i[c*5 +: 5] = t_bsh[c][4:0];
            bus.psum_i[c*32 +: 32]     = t_psum[c];
            m_acc[c] = int'(longint'(t_bias[c]) << t_bsh[c]);
        end
        bus.bias_valid_i = 1'b1;
        bus.psum_valid_i = with_psum;
        m_ovf    = 1'b0;
        m_in_acc = 1'b1;
        @(negedge clk);
        bus.bias_valid_i = 1'b0;
        bus.psum_valid_i = 1'b0;
        check_state(with_psum ? "bias+psum" : "bias");
    endtask

    task automatic do_psum();
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            longint s;
            bus.psum_i[c*32 +: 32] = t_psum[c];
            if (m_in_acc) begin
                s = longint'(m_acc[c]) + longint'(t_psum[c]);
                if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_ovf = 1'b1; end
                if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_ovf = 1'b1; end
                m_acc[c] = int'(s);
            end
        end
        bus.psum_valid_i = 1'b1;
        @(negedge clk);
        bus.psum_valid_i = 1'b0;
        check_state("psum");
    endtask

    task automatic load_quant_cfg();
        for (int c = 0; c < N; c++) begin
            bus.mul_i[c*16 +: 16] = t_mul[c][15:0];
            bus.shift_i[c*5 +: 5] = t_sh[c][4:0];
        end
        bus.relu_en_i = t_relu;
    endtask

    task automatic do_quant(input bit inject, input string tag);
        int first;
        int pulses;
        @(negedge clk);
        load_quant_cfg();
        bus.get_res_i = 1'b1;
        for (int c = 0; c < N; c++) m_res[c] = qmodel(m_acc[c], t_mul[c], t_sh[c], t_relu);
        m_in_acc = 1'b0;
        @(negedge clk);
        bus.get_res_i = 1'b0;
        bus.mul_i     = {N{16'h7fff}};
        bus.shift_i   = '0;
        bus.relu_en_i = ~t_relu;
        chk({tag, " busy after get"}, {63'd0, bus.busy_o}, 64'sd1);
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= N + 3; k++) begin
            if (inject && k == 2) begin
                bus.get_res_i    = 1'b1;
                bus.psum_valid_i = 1'b1;
                bus.bias_valid_i = 1'b1;
                bus.psum_i       = {$urandom, $urandom, $urandom, $urandom};
                bus.bias_i       = $urandom;
            end
            @(negedge clk);
            bus.get_res_i    = 1'b0;
            bus.psum_valid_i = 1'b0;
            bus.bias_valid_i = 1'b0;
            if (bus.res_valid_o) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == N + 1) chk({tag, " busy in done"}, {63'd0, bus.busy_o}, 64'sd0);
        end
        chk({tag, " latency"}, first, N + 1);
        chk({tag, " pulses"}, pulses, 1);
        check_res(tag);
        check_state({tag, " acc kept"});
    endtask

    task automatic do_reset_mid();
        int pulses;
        @(negedge clk);
        load_quant_cfg();
        bus.get_res_i = 1'b1;
        @(negedge clk);
        bus.get_res_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c < N; c++) begin
            m_acc[c] = 0;
            m_res[c] = 0;
        end
        m_ovf    = 1'b0;
        m_in_acc = 1'b0;
        check_state("rst mid");
        check_res("rst mid");
        chk("rst mid busy", {63'd0, bus.busy_o}, 64'sd0);
        chk("rst mid res_valid", {63'd0, bus.res_valid_o}, 64'sd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (bus.res_valid_o) pulses++;
        end
        chk("rst mid no pulse", pulses, 0);
        chk("rst mid busy after", {63'd0, bus.busy_o}, 64'sd0);
    endtask

    initial begin
        bus.bias_valid_i = 1'b0;
        bus.bias_i       = '0;
        bus.bias_shift_i = '0;
        bus.psum_valid_i = 1'b0;
        bus.psum_i       = '0;
        bus.mul_i        = '0;
        bus.shift_i      = '0;
        bus.relu_en_i    = 1'b0;
        bus.get_res_i    = 1'b0;
        for (int c = 0; c < N; c++) begin
            m_acc[c] = 0;
            m_res[c] = 0;
        end
        m_ovf    = 1'b0;
        m_in_acc = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset");
        check_res("reset");
        chk("reset busy", {63'd0, bus.busy_o}, 64'sd0);
        chk("reset res_valid", {63'd0, bus.res_valid_o}, 64'sd0);
        rst = 1'b0;

        t_bias = '{5, 7, -7, 125};
        t_bsh  = '{2, 0, 0, 3};
        t_psum = '{0, 0, 0, 0};
        do_bias(1'b0);
        t_psum = '{10, 0, 0, 0};
        do_psum();
        t_psum = '{-3, 0, 0, 0};
        do_psum();
        chk("acc ch0 27", $signed(bus.acc_o[31:0]), 27);
        t_mul  = '{1, 3, 3, 1};
        t_sh   = '{0, 2, 2, 0};
        t_relu = 1'b0;
        do_quant(1'b0, "q basic");
        chk("res ch0 27", $signed(bus.res_o[7:0]), 27);
        chk("res ch1 5", $signed(bus.res_o[15:8]), 5);
        chk("res ch2 -5", $signed(bus.res_o[23:16]), -5);
        chk("res ch3 sat 127", $signed(bus.res_o[31:24]), 127);

        t_bias = '{-125, -5, 0, 0};
        t_bsh  = '{3, 0, 0, 0};
        do_bias(1'b0);
        t_mul  = '{1, 1, 1, 1};
        t_sh   = '{0, 0, 0, 0};
        do_quant(1'b0, "q neg");
        chk("res ch0 sat -128", $signed(bus.res_o[7:0]), -128);
        t_relu = 1'b1;
        do_quant(1'b0, "q relu");
        chk("res ch1 relu 0", $signed(bus.res_o[15:8]), 0);

        t_bias = '{127, 0, 0, 0};
        t_bsh  = '{24, 0, 0, 0};
        do_bias(1'b0);
        t_psum = '{32'h00ff_fff0, 0, 0, 0};
        do_psum();
        t_psum = '{32'h0000_0100, 0, 0, 0};
        do_psum();
        chk("acc ch0 sat", $signed(bus.acc_o[31:0]), 32'sh7fff_ffff);
        chk("overflow set", {63'd0, bus.overflow_o}, 64'sd1);
        t_bias = '{1, -2, 3, -4};
        t_bsh  = '{0, 1, 2, 3};
        t_psum = '{1000, 1000, 1000, 1000};
        do_bias(1'b1);
        t_mul  = '{100, -100, 7, -7};
        t_sh   = '{1, 3, 0, 5};
        t_relu = 1'b0;
        do_quant(1'b1, "q inject");
        t_psum = '{50, 50, 50, 50};
        do_psum();
        do_reset_mid();

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N; c++) begin
                t_bias[c] = int'($urandom_range(0, 255)) - 128;
                t_bsh[c]  = int'($urandom_range(0, 31));
                t_mul[c]  = int'($urandom_range(0, 65535)) - 32768;
                t_sh[c]   = int'($urandom_range(0, 31));
            end
            t_relu = 1'($urandom_range(0, 1));
            do_bias(1'b0);
            for (int p = 0; p < 1 + (r % 3); p++) begin
                for (int c = 0; c < N; c++)
                    t_psum[c] = (r % 2 == 1) ? int'($urandom) : int'($urandom_range(0, 200000)) - 100000;
                do_psum();
            end
            do_quant(1'b0, $sformatf("rand%0d", r));
            if (r % 2 == 0) begin
                t_relu = ~t_relu;
                do_quant(1'b0, $sformatf("rand%0d again", r));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
